// File: rtl/bf_tx_arbiter.sv
// Two-requester byte arbiter feeding a single UART transmitter.
// CPU has fixed priority; debug is guaranteed a slot after STARVE_LIMIT back-to-back CPU grants.
module bf_tx_arbiter #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ACK_TIMEOUT  = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_valid_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic              cpu_ready_o,
   input  logic              dbg_valid_i,
   input  logic [DATA_W-1:0] dbg_data_i,
   output logic              dbg_ready_o,
   output logic              tx_start_o,
   output logic [DATA_W-1:0] tx_data_o,
   input  logic              tx_busy_i,
   output logic [1:0]        grant_o,
   output logic              ack_err_o
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

   state_t            r_state;
   logic [SW-1:0]     r_starve;
   logic [AW-1:0]     r_ack_cnt;
   logic              r_tx_start;
   logic [DATA_W-1:0] r_tx_data;
   logic [1:0]        r_grant;
   logic              r_ack_err;

   logic w_open;
   logic w_dbg_win;
   logic w_cpu_ready;
   logic w_dbg_ready;

   // Ready is gated by rst_i so both requesters see it drop the instant reset asserts.
   always_comb begin
      w_open      = rst_i && (r_state == IDLE) && !tx_busy_i;
      w_dbg_win   = dbg_valid_i && (!cpu_valid_i || (r_starve == SW'(STARVE_LIMIT)));
      w_cpu_ready = w_open && cpu_valid_i && !w_dbg_win;
      w_dbg_ready = w_open && w_dbg_win;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= IDLE;
         r_starve   <= '0;
         r_ack_cnt  <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_grant    <= '0;
         r_ack_err  <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_cpu_ready) begin
                  r_tx_data  <= cpu_data_i;
                  r_grant    <= 2'b01;
                  r_tx_start <= 1'b1;
                  r_state    <= LAUNCH;
                  if (!dbg_valid_i)
                     r_starve <= '0;
                  else if (r_starve != SW'(STARVE_LIMIT))
                     r_starve <= r_starve + SW'(1);
               end else if (w_dbg_ready) begin
                  r_tx_data  <= dbg_data_i;
                  r_grant    <= 2'b10;
                  r_tx_start <= 1'b1;
                  r_state    <= LAUNCH;
                  r_starve   <= '0;
               end
            end
            LAUNCH: begin
               r_ack_cnt <= '0;
               r_state   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (tx_busy_i) begin
                  r_state <= WAIT_DONE;
               end else if (r_ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                  // Counter would reach ACK_TIMEOUT on this edge: give up on the byte.
                  r_ack_err <= 1'b1;
                  r_grant   <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_ack_cnt <= r_ack_cnt + AW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy_i) begin
                  r_grant <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cpu_ready_o = w_cpu_ready;
   assign dbg_ready_o = w_dbg_ready;
   assign tx_start_o  = r_tx_start;
   assign tx_data_o   = r_tx_data;
   assign grant_o     = r_grant;
   assign ack_err_o   = r_ack_err;

endmodule
